// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
// Shared types and default constants for the PPU OAM address controller.
//   oam_state_e   : OAM DMA sequencer states (IDLE, XFER)
//   PPU_*         : default timing / sizing constants
//   cnt_width()   : width of the DMA byte counter for a given transfer length
// ---------------------------------------------------------------------------
package ppu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } oam_state_e;

  localparam int PPU_ADDR_W    = 8;
  localparam int PPU_DMA_LEN   = 256;
  localparam int PPU_CLR_START = 257;
  localparam int PPU_CLR_END   = 320;
  localparam int PPU_EVAL_TICK = 65;

  // The counter must hold DMA_LEN itself and always expose at least the
  // 8 low bits that form the low byte of the DMA source address.
  function automatic int cnt_width(input int len);
    return ($clog2(len + 1) < 8) ? 8 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/ppu_oam_dma_seq.sv
// ---------------------------------------------------------------------------
// ppu_oam_dma_seq
// OAM DMA byte sequencer: owns the DMA page/count registers and the
// IDLE/XFER FSM. It does not own OAMADDR; it hands an increment request and
// the selected write byte to the address register in the top level.
//
// Handshake: a byte is accepted on every clock where the FSM is in XFER and
// i_dma_valid is high; there is no back-pressure, the source simply holds
// i_dma_valid low when it has no byte.
//
// Ports
//   i_clk, i_rst_n : clock, async active-low reset
//   i_dma_start    : start strobe (page in i_cpu_din), ignored while busy
//   i_dma_valid    : DMA source byte present this cycle
//   i_cpu_din      : CPU write data (page on start, OAMDATA byte otherwise)
//   i_dma_din      : DMA source byte
//   o_busy         : FSM is in XFER
//   o_done         : high in the cycle the last byte is accepted
//   o_inc_req      : byte accepted this cycle (write OAM, bump OAMADDR)
//   o_wdata        : OAM write byte (DMA byte in XFER, CPU byte otherwise)
//   o_src_addr     : CPU address of the next DMA byte {page, count[7:0]}
//   o_state        : debug view of the FSM state
// ---------------------------------------------------------------------------
module ppu_oam_dma_seq
  import ppu_pkg::*;
#(
  parameter int DMA_LEN = PPU_DMA_LEN
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_dma_start,
  input  logic        i_dma_valid,
  input  logic [7:0]  i_cpu_din,
  input  logic [7:0]  i_dma_din,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_inc_req,
  output logic [7:0]  o_wdata,
  output logic [15:0] o_src_addr,
  output oam_state_e  o_state
);

  localparam int               CNT_W = cnt_width(DMA_LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DMA_LEN - 1);

  oam_state_e       r_state;
  oam_state_e       w_state_nxt;
  logic [7:0]       r_page;
  logic [7:0]       w_page_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_take;
  logic             w_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_page  <= 8'h00;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_page  <= w_page_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_page_nxt  = r_page;
    w_count_nxt = r_count;
    w_take      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_dma_start) begin
          w_state_nxt = XFER;
          w_page_nxt  = i_cpu_din;
          w_count_nxt = '0;
        end
      end
      XFER: begin
        if (i_dma_valid) begin
          w_take      = 1'b1;
          w_count_nxt = r_count + CNT_W'(1);
          if (r_count == LAST) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_busy     = (r_state == XFER);
  assign o_done     = w_done;
  assign o_inc_req  = w_take;
  assign o_wdata    = (r_state == XFER) ? i_dma_din : i_cpu_din;
  assign o_src_addr = {r_page, r_count[7:0]};
  assign o_state    = r_state;

endmodule

// File: rtl/ppu_oam_addr_ctrl.sv
// ---------------------------------------------------------------------------
// ppu_oam_addr_ctrl
// OAM address / write controller. Owns OAMADDR, sequences OAMDATA writes and
// OAM DMA, clears OAMADDR during the render clear window and captures the
// sprite-evaluation base address.
//
// Ports
//   i_clk, i_rst_n   : PPU clock, async active-low reset
//   i_oamaddr_wr     : CPU write strobe 0x2003 (data in i_cpu_din)
//   i_oamdata_wr     : CPU write strobe 0x2004 (data in i_cpu_din)
//   i_cpu_din        : CPU write data
//   i_dma_start      : CPU write strobe 0x4014 (page in i_cpu_din)
//   i_dma_valid      : DMA source byte available this cycle
//   i_dma_din        : DMA source byte
//   i_render_en      : sprite or background rendering enabled
//   i_line_active    : pre-render or visible scanline
//   i_tick           : PPU dot counter 0..340
//   o_dma_src_addr   : CPU address of next DMA byte
//   o_dma_busy       : DMA in progress
//   o_dma_done       : high in the cycle the last DMA byte is written
//   o_oam_we         : OAM RAM write enable
//   o_oam_waddr      : OAM RAM write address
//   o_oam_wdata      : OAM RAM write data
//   o_oamaddr_out    : current OAMADDR
//   o_eval_base      : OAMADDR captured at EVAL_TICK while rendering
// ---------------------------------------------------------------------------
module ppu_oam_addr_ctrl
  import ppu_pkg::*;
#(
  parameter int ADDR_W    = PPU_ADDR_W,
  parameter int DMA_LEN   = PPU_DMA_LEN,
  parameter int CLR_START = PPU_CLR_START,
  parameter int CLR_END   = PPU_CLR_END,
  parameter int EVAL_TICK = PPU_EVAL_TICK
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_oamaddr_wr,
  input  logic              i_oamdata_wr,
  input  logic [7:0]        i_cpu_din,
  input  logic              i_dma_start,
  input  logic              i_dma_valid,
  input  logic [7:0]        i_dma_din,
  input  logic              i_render_en,
  input  logic              i_line_active,
  input  logic [8:0]        i_tick,
  output logic [15:0]       o_dma_src_addr,
  output logic              o_dma_busy,
  output logic              o_dma_done,
  output logic              o_oam_we,
  output logic [ADDR_W-1:0] o_oam_waddr,
  output logic [7:0]        o_oam_wdata,
  output logic [ADDR_W-1:0] o_oamaddr_out,
  output logic [ADDR_W-1:0] o_eval_base
);

  localparam logic [8:0] CLR_START_T = 9'(CLR_START);
  localparam logic [8:0] CLR_END_T   = 9'(CLR_END);
  localparam logic [8:0] EVAL_TICK_T = 9'(EVAL_TICK);

  logic [ADDR_W-1:0] r_oamaddr;
  logic [ADDR_W-1:0] w_oamaddr_nxt;
  logic [ADDR_W-1:0] r_eval_base;
  logic              w_rendering;
  logic              w_clr_win;
  logic              w_busy;
  logic              w_inc_req;
  logic              w_cpu_wr;
  logic [7:0]        w_wdata;
  oam_state_e        w_state;

  ppu_oam_dma_seq #(
    .DMA_LEN (DMA_LEN)
  ) u_dma_seq (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_dma_start (i_dma_start),
    .i_dma_valid (i_dma_valid),
    .i_cpu_din   (i_cpu_din),
    .i_dma_din   (i_dma_din),
    .o_busy      (w_busy),
    .o_done      (o_dma_done),
    .o_inc_req   (w_inc_req),
    .o_wdata     (w_wdata),
    .o_src_addr  (o_dma_src_addr),
    .o_state     (w_state)
  );

  assign w_rendering = i_render_en && i_line_active;
  assign w_clr_win   = w_rendering && (i_tick >= CLR_START_T) && (i_tick <= CLR_END_T);

  // CPU OAMDATA writes reach the RAM only when idle and not rendering;
  // during rendering the write is dropped and only the address glitch remains.
  assign w_cpu_wr = (w_state == IDLE) && i_oamdata_wr && !w_rendering;

  always_comb begin
    w_oamaddr_nxt = r_oamaddr;
    if (w_clr_win) begin
      w_oamaddr_nxt = '0;
    end else if (!w_busy && i_oamaddr_wr) begin
      w_oamaddr_nxt = ADDR_W'(i_cpu_din);
    end else if (w_inc_req) begin
      w_oamaddr_nxt = r_oamaddr + ADDR_W'(1);
    end else if (!w_busy && i_oamdata_wr) begin
      w_oamaddr_nxt = r_oamaddr + (w_rendering ? ADDR_W'(4) : ADDR_W'(1));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_oamaddr   <= '0;
      r_eval_base <= '0;
    end else begin
      r_oamaddr <= w_oamaddr_nxt;
      if (w_rendering && (i_tick == EVAL_TICK_T)) begin
        r_eval_base <= r_oamaddr;
      end
    end
  end

  assign o_dma_busy    = w_busy;
  assign o_oam_we      = w_inc_req || w_cpu_wr;
  assign o_oam_waddr   = r_oamaddr;
  assign o_oam_wdata   = w_wdata;
  assign o_oamaddr_out = r_oamaddr;
  assign o_eval_base   = r_eval_base;

endmodule

// File: tb/tb_ppu_oam_addr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ppu_oam_addr_ctrl
// Directed bench for ppu_oam_addr_ctrl. Inputs change 1 ns after the rising
// edge; outputs are checked after that settling delay, away from the edge.
// oam_mem mirrors the OAM RAM from the write port so write contents can be
// checked against hand-computed bytes.
// ---------------------------------------------------------------------------
module tb_ppu_oam_addr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        oamaddr_wr = 1'b0;
  logic        oamdata_wr = 1'b0;
  logic [7:0]  cpu_din = 8'h00;
  logic        dma_start = 1'b0;
  logic        dma_valid = 1'b0;
  logic [7:0]  dma_din = 8'h00;
  logic        render_en = 1'b0;
  logic        line_active = 1'b0;
  logic [8:0]  tick = 9'd0;
  logic [15:0] dma_src_addr;
  logic        dma_busy;
  logic        dma_done;
  logic        oam_we;
  logic [7:0]  oam_waddr;
  logic [7:0]  oam_wdata;
  logic [7:0]  oamaddr_out;
  logic [7:0]  eval_base;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  logic [7:0]  oam_mem [256];

  ppu_oam_addr_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_oamaddr_wr   (oamaddr_wr),
    .i_oamdata_wr   (oamdata_wr),
    .i_cpu_din      (cpu_din),
    .i_dma_start    (dma_start),
    .i_dma_valid    (dma_valid),
    .i_dma_din      (dma_din),
    .i_render_en    (render_en),
    .i_line_active  (line_active),
    .i_tick         (tick),
    .o_dma_src_addr (dma_src_addr),
    .o_dma_busy     (dma_busy),
    .o_dma_done     (dma_done),
    .o_oam_we       (oam_we),
    .o_oam_waddr    (oam_waddr),
    .o_oam_wdata    (oam_wdata),
    .o_oamaddr_out  (oamaddr_out),
    .o_eval_base    (eval_base)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- OAM RAM model and dma_done pulse counter ----
  always @(posedge clk) begin
    if (oam_we) oam_mem[oam_waddr] <= oam_wdata;
    if (dma_done) done_cnt <= done_cnt + 1;
  end

  // ---- driver helpers ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    oamaddr_wr = 1'b0;
    oamdata_wr = 1'b0;
    dma_start  = 1'b0;
    dma_valid  = 1'b0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- directed sequence ----
  initial begin : main
    logic [7:0] exp_addr;
    logic       wr;
    int         k;
    int         i;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_oamaddr", 16'(oamaddr_out), 16'h0000);
    check("rst_eval_base", 16'(eval_base), 16'h0000);
    check("rst_busy", 16'(dma_busy), 16'h0000);
    check("rst_we", 16'(oam_we), 16'h0000);
    check("rst_done", 16'(dma_done), 16'h0000);
    check("rst_src_addr", dma_src_addr, 16'h0000);
    rst_n = 1'b1;
    step();

    // 1. OAMADDR=0x10 then three OAMDATA writes
    oamaddr_wr = 1'b1; cpu_din = 8'h10; step(); clear_strobes();
    oamdata_wr = 1'b1; cpu_din = 8'hAA; #1;
    check("t1_we", 16'(oam_we), 16'h0001);
    check("t1_waddr", 16'(oam_waddr), 16'h0010);
    step();
    cpu_din = 8'hBB; step();
    cpu_din = 8'hCC; step(); clear_strobes();
    check("t1_mem10", 16'(oam_mem[8'h10]), 16'h00AA);
    check("t1_mem11", 16'(oam_mem[8'h11]), 16'h00BB);
    check("t1_mem12", 16'(oam_mem[8'h12]), 16'h00CC);
    check("t1_oamaddr", 16'(oamaddr_out), 16'h0013);

    // 2. Write at 0xFF wraps OAMADDR to 0
    oamaddr_wr = 1'b1; cpu_din = 8'hFF; step(); clear_strobes();
    oamdata_wr = 1'b1; cpu_din = 8'h55; step(); clear_strobes();
    check("t2_memff", 16'(oam_mem[8'hFF]), 16'h0055);
    check("t2_wrap", 16'(oamaddr_out), 16'h0000);

    // 3. DMA page 0x02 with gaps; OAMADDR write mid-DMA is ignored
    done_cnt = 0;
    dma_start = 1'b1; cpu_din = 8'h02; step(); clear_strobes();
    check("t3_busy", 16'(dma_busy), 16'h0001);
    i = 0;
    k = 0;
    while (i < 256 && k < 2000) begin
      if ((k % 5) == 2) begin
        dma_valid = 1'b0;
        step();
      end else begin
        check("t3_src_addr", dma_src_addr, 16'h0200 + 16'(i));
        dma_valid = 1'b1;
        dma_din   = 8'(i) ^ 8'h5A;
        if (i == 50) begin
          oamaddr_wr = 1'b1;
          cpu_din    = 8'h99;
        end
        step();
        clear_strobes();
        if (i == 50) check("t3_addr_wr_ignored", 16'(oamaddr_out), 16'h0033);
        i++;
      end
      k++;
    end
    check("t3_byte_count", 16'(i), 16'd256);
    check("t3_busy_end", 16'(dma_busy), 16'h0000);
    check("t3_done_pulses", 16'(done_cnt), 16'h0001);
    check("t3_oamaddr_end", 16'(oamaddr_out), 16'h0000);
    for (int j = 0; j < 256; j++) begin
      check("t3_mem", 16'(oam_mem[j]), 16'(8'(j) ^ 8'h5A));
    end

    // 4. Rendering clear window and eval_base capture
    render_en = 1'b1; line_active = 1'b1; tick = 9'd249;
    oamaddr_wr = 1'b1; cpu_din = 8'h20; step(); clear_strobes();
    check("t4_setup", 16'(oamaddr_out), 16'h0020);
    exp_addr = 8'h20;
    for (int t = 250; t <= 330; t++) begin
      tick = 9'(t);
      wr   = (t == 256) || (t == 320) || (t == 321);
      oamdata_wr = wr;
      #1;
      if (wr) check("t4_no_we", 16'(oam_we), 16'h0000);
      step();
      clear_strobes();
      if (t >= 257 && t <= 320) exp_addr = 8'h00;
      else if (wr) exp_addr = exp_addr + 8'h04;
      check("t4_sweep", 16'(oamaddr_out), 16'(exp_addr));
    end
    check("t4_eval_hold", 16'(eval_base), 16'h0000);
    for (int t = 0; t <= 65; t++) begin
      tick = 9'(t);
      if (t == 10) begin
        oamaddr_wr = 1'b1;
        cpu_din    = 8'h08;
      end
      step();
      clear_strobes();
      if (t == 64) check("t4_eval_before", 16'(eval_base), 16'h0000);
    end
    check("t4_eval_capture", 16'(eval_base), 16'h0008);

    // 5. Rendering glitch increment, wrap, and same-cycle priority
    tick = 9'd100;
    oamaddr_wr = 1'b1; cpu_din = 8'h06; step(); clear_strobes();
    oamdata_wr = 1'b1; cpu_din = 8'h77; #1;
    check("t5_no_we", 16'(oam_we), 16'h0000);
    step(); clear_strobes();
    check("t5_plus4", 16'(oamaddr_out), 16'h000A);
    oamaddr_wr = 1'b1; cpu_din = 8'hFE; step(); clear_strobes();
    oamdata_wr = 1'b1; step(); clear_strobes();
    check("t5_plus4_wrap", 16'(oamaddr_out), 16'h0002);
    oamaddr_wr = 1'b1; oamdata_wr = 1'b1; cpu_din = 8'h33; step(); clear_strobes();
    check("t5_priority", 16'(oamaddr_out), 16'h0033);

    // 6. Reset mid-DMA aborts, then a full DMA runs
    render_en = 1'b0; line_active = 1'b0; tick = 9'd0;
    oamaddr_wr = 1'b1; cpu_din = 8'h00; step(); clear_strobes();
    done_cnt = 0;
    dma_start = 1'b1; cpu_din = 8'h03; step(); clear_strobes();
    for (int j = 0; j < 100; j++) begin
      dma_valid = 1'b1; dma_din = 8'(j); step();
    end
    clear_strobes();
    check("t6_src_at_100", dma_src_addr, 16'h0364);
    rst_n = 1'b0; #1;
    check("t6_abort_busy", 16'(dma_busy), 16'h0000);
    check("t6_abort_oamaddr", 16'(oamaddr_out), 16'h0000);
    check("t6_abort_eval", 16'(eval_base), 16'h0000);
    step();
    rst_n = 1'b1;
    step();
    check("t6_no_done", 16'(done_cnt), 16'h0000);
    dma_start = 1'b1; cpu_din = 8'h04; step(); clear_strobes();
    for (int j = 0; j < 256; j++) begin
      if (j == 255) check("t6_src_last", dma_src_addr, 16'h04FF);
      dma_valid = 1'b1; dma_din = ~8'(j); step();
    end
    clear_strobes();
    check("t6_busy_end", 16'(dma_busy), 16'h0000);
    check("t6_done_pulses", 16'(done_cnt), 16'h0001);
    check("t6_oamaddr_end", 16'(oamaddr_out), 16'h0000);
    check("t6_mem00", 16'(oam_mem[8'h00]), 16'h00FF);
    check("t6_mem64", 16'(oam_mem[8'h64]), 16'h009B);
    check("t6_memff", 16'(oam_mem[8'hFF]), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
